// File: rtl/imem_loader_ctrl_if.sv
// imem_loader_ctrl_if: load channel and fetch port bundle for imem_loader_ctrl
//   load_*  : load_start/load_len begin a load; load_valid/load_data/load_ready stream words; load_done marks the last write
//   fetch_* : fetch_req/fetch_addr request a word; fetch_valid/fetch_data/fetch_err answer one cycle later
//   busy/loaded : loader status
interface imem_loader_ctrl_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
);
    logic              load_start;
    logic [ADDR_W:0]   load_len;
    logic              load_valid;
    logic [DATA_W-1:0] load_data;
    logic              load_ready;
    logic              load_done;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;
    logic              busy;
    logic              loaded;

    modport master (
        output load_start, load_len, load_valid, load_data, fetch_req, fetch_addr,
        input  load_ready, load_done, fetch_valid, fetch_data, fetch_err, busy, loaded
    );

    modport slave (
        input  load_start, load_len, load_valid, load_data, fetch_req, fetch_addr,
        output load_ready, load_done, fetch_valid, fetch_data, fetch_err, busy, loaded
    );
endinterface

// File: rtl/imem_loader_ctrl.sv
// imem_loader_ctrl: instruction memory with streaming program loader and 1-cycle registered fetch port
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : imem_loader_ctrl_if.slave (load channel, fetch port, busy/loaded status)
//   IMEM_PARITY_EN : when defined, each word carries an even-parity bit checked on fetch
module imem_loader_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input logic clk,
    input logic rst_n,
    imem_loader_ctrl_if.slave bus
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wptr;
    logic [ADDR_W:0]   cnt, target;
    logic              start_ok, accept, last, fetch_ok, in_range, rd_err;
    logic [DATA_W-1:0] rd_word;
    logic              load_done_q, loaded_q, fetch_valid_q, fetch_err_q;
    logic [DATA_W-1:0] fetch_data_q;

    assign start_ok = bus.load_start && bus.load_len != '0;
    assign accept   = state_q == LOAD && bus.load_valid;
    assign last     = cnt + (ADDR_W+1)'(1) == target;
    assign fetch_ok = state_q == RUN && bus.fetch_req;
    assign in_range = {1'b0, bus.fetch_addr} < DEPTH_W;
    assign rd_word  = in_range ? mem[bus.fetch_addr] : '0;

`ifdef IMEM_PARITY_EN
    logic par [DEPTH];
    always_ff @(posedge clk)
        if (accept) par[wptr] <= ^bus.load_data;
    // raw word is still returned on a parity fault; only the error flag reports it
    assign rd_err = !in_range || (^rd_word != par[bus.fetch_addr]);
`else
    assign rd_err = !in_range;
`endif

    always_comb begin
        state_d = state_q;
        if (state_q == LOAD) state_d = (accept && last) ? RUN : LOAD;
        else if (start_ok)   state_d = LOAD;
    end

    always_ff @(posedge clk)
        if (accept) mem[wptr] <= bus.load_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wptr          <= '0;
            cnt           <= '0;
            target        <= '0;
            load_done_q   <= 1'b0;
            loaded_q      <= 1'b0;
            fetch_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
            fetch_data_q  <= '0;
        end else begin
            state_q       <= state_d;
            load_done_q   <= accept && last;
            fetch_valid_q <= fetch_ok;
            fetch_err_q   <= fetch_ok && rd_err;
            // a fetch accepted alongside load_start reads pre-load contents: writes start next cycle
            if (fetch_ok) fetch_data_q <= rd_word;
            if (state_q != LOAD && start_ok) begin
                target   <= bus.load_len > DEPTH_W ? DEPTH_W : bus.load_len;
                cnt      <= '0;
                wptr     <= '0;
                loaded_q <= 1'b0;
            end else if (accept) begin
                cnt  <= cnt + (ADDR_W+1)'(1);
                wptr <= wptr + ADDR_W'(1);
                if (last) loaded_q <= 1'b1;
            end
        end
    end

    assign bus.load_ready  = state_q == LOAD;
    assign bus.busy        = state_q == LOAD;
    assign bus.load_done   = load_done_q;
    assign bus.loaded      = loaded_q;
    assign bus.fetch_valid = fetch_valid_q;
    assign bus.fetch_err   = fetch_err_q;
    assign bus.fetch_data  = fetch_data_q;
endmodule

// File: tb/tb_imem_loader_ctrl.sv
// tb_imem_loader_ctrl: directed bench with a behavioural memory/loader model compared every cycle
module tb_imem_loader_ctrl;
    localparam int DW = 32, AW = 10, DEPTH = 1000;
    logic clk = 1'b0, rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
    imem_loader_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave)
    );

    int checks = 0, failures = 0, accepts = 0, dones = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // model: program image plus two flags; RUN is simply "loaded"
    logic [DW-1:0] mm [DEPTH];
    bit            flip [DEPTH];
    bit            m_loading = 0, m_loaded = 0, e_valid = 0, e_err = 0, e_done = 0;
    logic [DW-1:0] e_data = '0;
    int            m_target = 0, m_written = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_loading = 0; m_loaded = 0; e_valid = 0; e_err = 0; e_done = 0; e_data = '0;
        end else begin
            e_valid = m_loaded && bus.fetch_req;
            e_err = 0;
            if (e_valid) begin
                if (int'(bus.fetch_addr) >= DEPTH) begin
                    e_err = 1; e_data = '0;
                end else begin
                    e_err = flip[bus.fetch_addr]; e_data = mm[bus.fetch_addr];
                end
            end
            e_done = 0;
            if (m_loading) begin
                if (bus.load_valid) begin
                    mm[m_written] = bus.load_data;
                    flip[m_written] = 0;
                    m_written++;
                    if (m_written == m_target) begin
                        e_done = 1; m_loading = 0; m_loaded = 1;
                    end
                end
            end else if (bus.load_start && bus.load_len != 0) begin
                m_loading = 1; m_loaded = 0; m_written = 0;
                m_target = int'(bus.load_len) > DEPTH ? DEPTH : int'(bus.load_len);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", bus.busy, m_loading);
        chk("load_ready", bus.load_ready, m_loading);
        chk("load_done", bus.load_done, e_done);
        chk("loaded", bus.loaded, m_loaded);
        chk("fetch_valid", bus.fetch_valid, e_valid);
        chk("fetch_err", bus.fetch_err, e_err);
        chk("fetch_data", bus.fetch_data, e_data);
        if (bus.load_valid && bus.load_ready) accepts++;
        if (bus.load_done) dones++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int len);
        bus.load_start = 1'b1;
        bus.load_len = (AW+1)'(len);
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic fetch(input int a);
        bus.fetch_req = 1'b1;
        bus.fetch_addr = AW'(a);
        tick();
        bus.fetch_req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, d0, k;
        int pat [5] = '{1, 0, 1, 0, 1};
        bus.load_start = 0; bus.load_len = '0; bus.load_valid = 0; bus.load_data = '0;
        bus.fetch_req = 0; bus.fetch_addr = '0;
        repeat (2) tick();
        chk("rst_busy", bus.busy, 0);
        chk("rst_ready", bus.load_ready, 0);
        chk("rst_loaded", bus.loaded, 0);
        chk("rst_fdata", bus.fetch_data, 0);
        rst_n = 1'b1;
        tick();

        // basic load of 4 words, then back-to-back fetches
        a0 = accepts; d0 = dones;
        start(4);
        bus.load_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.load_data = 32'hA0 + 32'(i);
            tick();
        end
        bus.load_valid = 1'b0;
        chk("t1_done", bus.load_done, 1);
        chk("t1_loaded", bus.loaded, 1);
        chk("t1_busy", bus.busy, 0);
        tick();
        chk("t1_accepts", accepts - a0, 4);
        chk("t1_dones", dones - d0, 1);
        for (int i = 0; i < 4; i++) begin
            bus.fetch_req = 1'b1;
            bus.fetch_addr = AW'(i);
            tick();
            chk("t1_fvalid", bus.fetch_valid, 1);
            chk("t1_fdata", bus.fetch_data, 32'hA0 + 32'(i));
            chk("t1_ferr", bus.fetch_err, 0);
        end
        bus.fetch_req = 1'b0;
        tick();

        // handshake gaps: 3 words over 5 cycles
        start(3);
        k = 0;
        for (int c = 0; c < 5; c++) begin
            bus.load_valid = pat[c][0];
            bus.load_data = 32'hB0 + 32'(k);
            tick();
            if (pat[c] == 1) k++;
            if (c == 3) chk("t2_done_early", bus.load_done, 0);
        end
        bus.load_valid = 1'b0;
        chk("t2_done", bus.load_done, 1);
        for (int i = 0; i < 3; i++) begin
            fetch(i);
            chk("t2_fdata", bus.fetch_data, 32'hB0 + 32'(i));
        end

        // clamp to DEPTH and out-of-range fetch
        a0 = accepts;
        start(1024);
        bus.load_valid = 1'b1;
        for (int i = 0; i < 1005; i++) begin
            bus.load_data = 32'hC000 + 32'(i);
            tick();
        end
        bus.load_valid = 1'b0;
        tick();
        chk("t3_accepts", accepts - a0, 1000);
        chk("t3_loaded", bus.loaded, 1);
        fetch(999);
        chk("t3_last", bus.fetch_data, 32'hC3E7);
        chk("t3_last_err", bus.fetch_err, 0);
        fetch(1000);
        chk("t3_oor_valid", bus.fetch_valid, 1);
        chk("t3_oor_err", bus.fetch_err, 1);
        chk("t3_oor_data", bus.fetch_data, 0);
        tick();
        chk("t3_err_pulse", bus.fetch_err, 0);

        // lockout in IDLE and LOAD, then reset mid-load
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        bus.fetch_req = 1'b1;
        bus.fetch_addr = '0;
        repeat (2) tick();
        chk("t4_idle_fvalid", bus.fetch_valid, 0);
        start(8);
        bus.fetch_req = 1'b1;
        bus.load_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.load_data = 32'hD0 + 32'(i);
            tick();
        end
        chk("t4_load_fvalid", bus.fetch_valid, 0);
        chk("t4_load_busy", bus.busy, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("t4_rst_ready", bus.load_ready, 0);
        chk("t4_rst_busy", bus.busy, 0);
        chk("t4_rst_loaded", bus.loaded, 0);
        bus.fetch_req = 1'b0;
        bus.load_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // reload from RUN with a fetch in the load_start cycle
        start(3);
        bus.load_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.load_data = 32'hE0 + 32'(i);
            tick();
        end
        bus.load_valid = 1'b0;
        tick();
        bus.fetch_req = 1'b1;
        bus.fetch_addr = AW'(0);
        tick();
        chk("t5_f0", bus.fetch_data, 32'hE0);
        bus.fetch_addr = AW'(1);
        tick();
        chk("t5_f1", bus.fetch_data, 32'hE1);
        bus.fetch_addr = AW'(2);
        bus.load_start = 1'b1;
        bus.load_len = (AW+1)'(2);
        tick();
        bus.load_start = 1'b0;
        bus.fetch_req = 1'b0;
        chk("t5_f2_valid", bus.fetch_valid, 1);
        chk("t5_f2_old", bus.fetch_data, 32'hE2);
        chk("t5_busy", bus.busy, 1);
        bus.load_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            bus.load_data = 32'hF0 + 32'(i);
            tick();
        end
        bus.load_valid = 1'b0;
        tick();
        fetch(0);
        chk("t5_new0", bus.fetch_data, 32'hF0);
        fetch(1);
        chk("t5_new1", bus.fetch_data, 32'hF1);
        fetch(2);
        chk("t5_keep2", bus.fetch_data, 32'hE2);

`ifdef IMEM_PARITY_EN
        dut.mem[0] = dut.mem[0] ^ 32'h4;
        mm[0] = mm[0] ^ 32'h4;
        flip[0] = 1;
        fetch(0);
        chk("t6_par_err", bus.fetch_err, 1);
        chk("t6_par_data", bus.fetch_data, 32'hF4);
`endif

        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/imem_loader_ctrl.md
Name: imem_loader_ctrl

Overview:
- Parametrised instruction memory with a built-in program loader.
- Replaces the fixed 1024x32 distributed-RAM wrapper.
- A load channel streams program words in with a valid/ready handshake and auto-incremented write address; a fetch port serves the CPU front end with 1-cycle registered read.
- A control FSM locks out fetches during load and reports load completion and fetch errors.

Parameters:
- DATA_W, 32: instruction word width in bits.
- ADDR_W, 10: word address width for the fetch port and write pointer.
- DEPTH, 1024: number of words implemented; must be <= 2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load_start  in  1  pulse that begins a program load.
- load_len  in  ADDR_W+1  number of words to load; sampled with load_start.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  program word.
- load_ready  out  1  loader accepts a word this cycle.
- load_done  out  1  one-cycle pulse when the final word is written.
- fetch_req  in  1  fetch request.
- fetch_addr  in  ADDR_W  word address of the fetch.
- fetch_valid  out  1  fetch_data/fetch_err valid, one cycle after an accepted request.
- fetch_data  out  DATA_W  fetched instruction.
- fetch_err  out  1  fetch fault (out of range; parity when enabled).
- busy  out  1  FSM is in LOAD.
- loaded  out  1  a complete program is resident.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - load_ready, load_done, fetch_valid, fetch_err, busy, loaded = 0.
  - fetch_data = 0; write pointer = 0; word counter = 0.
  - Memory array contents are not reset.
- FSM states: IDLE, LOAD, RUN.
- IDLE:
  - load_start with load_len != 0 -> LOAD.
  - fetch_req is ignored; fetch_valid stays 0.
- LOAD:
  - busy = 1, load_ready = 1, loaded = 0.
  - Entry: write pointer = 0; target = min(load_len, DEPTH).
  - Each cycle with load_valid && load_ready: mem[wptr] <= load_data, wptr++, counter++.
  - When the accepted word is number target: load_done pulses that same cycle (registered, visible next cycle), load_ready drops the following cycle, loaded = 1, FSM -> RUN.
  - load_start is ignored in LOAD.
  - fetch_req is ignored; no fetch_valid is produced.
- RUN:
  - Fetch accepted on any cycle with fetch_req = 1; there is no backpressure.
  - Next cycle: fetch_valid = 1, fetch_data = mem[fetch_addr].
  - If fetch_addr >= DEPTH: fetch_err = 1 and fetch_data = 0.
  - Back-to-back requests give a result every cycle at 1-cycle latency.
  - With load_start and load_len != 0: -> LOAD, loaded = 0. A fetch accepted in that same cycle still completes next cycle.
  - load_start with load_len = 0 is a no-op in every state.
- Simultaneous fetch_req and load_start in RUN: the fetch is served from pre-load contents.
- load_len > DEPTH is clamped to DEPTH; no wrap-around writes occur.
- Reset mid-LOAD: FSM -> IDLE, loaded = 0; partially written words remain in the array but are not trusted.
- fetch_valid and fetch_err are single-cycle per request; fetch_data holds its value until the next accepted fetch.
- Memory: DEPTH x DATA_W array, one synchronous write port (loader) and one read port (fetch, registered output).

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from load_data at write time.
  - On fetch, parity is recomputed. A mismatch sets fetch_err = 1 alongside fetch_valid, but fetch_data still carries the raw stored word.
  - Out-of-range fetches still report fetch_err.
- Undefined: no parity storage or logic; fetch_err reports out-of-range only.

Test Plan:
- Reset then load: load_start, load_len = 4, words 0xA0..0xA3 with load_valid held high -> load_ready high for 4 accepts, load_done pulses once, loaded = 1, busy = 0; fetches of addr 0..3 return 0xA0..0xA3 at 1-cycle latency, fetch_err = 0.
- Handshake gaps: load_len = 3 with load_valid toggling 1,0,1,0,1 -> exactly 3 writes at addresses 0,1,2; load_done fires on the 5th cycle.
- Clamp and range (DEPTH = 1000, ADDR_W = 10): load_len = 1024 -> exactly 1000 words accepted; fetch addr 999 returns the last word; fetch addr 1000 -> fetch_valid = 1, fetch_err = 1, fetch_data = 0.
- Lockout and mid-load reset: fetch_req during IDLE and LOAD -> no fetch_valid; assert rst_n = 0 after 2 of 8 words -> FSM IDLE, loaded = 0, load_ready = 0 immediately.
- Reload from RUN: back-to-back fetches of addr 0,1,2 then load_start (load_len = 2) in the same cycle as the fetch of addr 2 -> addr 2 returns the old word; after reload, addr 0..1 return new data and addr 2 still returns the old word.
- With IMEM_PARITY_EN: load a word, then force-flip a stored bit via a hierarchical deposit -> fetch_err = 1 on the fetch, fetch_data = the corrupted raw word.
